// File: rtl/axi_stream_pkg.sv
// Shared AXI-Stream helpers for the header insert/strip pair.
// Pure types and functions; no state.
// Not applicable: no handshake lives here.
package axi_stream_pkg;

  // Largest byte-lane count the keep helpers handle; callers zero-extend or truncate.
  localparam int MAX_BYTES = 64;
  localparam int CNT_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_TAIL = 2'd2
  } axis_state_t;

  // Number of asserted keep bits.
  function automatic logic [CNT_W-1:0] keep_to_cnt(input logic [MAX_BYTES-1:0] keep);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      c = c + CNT_W'(keep[i]);
    end
    return c;
  endfunction

  // MSB-contiguous keep of cnt ones inside an nbytes-wide keep field.
  function automatic logic [MAX_BYTES-1:0] cnt_to_keep(input logic [CNT_W-1:0] cnt,
                                                       input int nbytes);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((i < nbytes) && (i >= nbytes - int'(cnt))) begin
        k[i] = 1'b1;
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/axis_byte_align.sv
// Byte realignment: splits a beat at lane n into header/carry and merges with the residual.
// Combinational, zero latency.
// No handshake; the caller decides when the results are used.
module axis_byte_align #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic [DATA_WD-1:0]     residual,
  input  logic [DATA_WD-1:0]     data_in,
  input  logic [BYTE_CNT_WD-1:0] n,
  output logic [DATA_WD-1:0]     merged,
  output logic [DATA_WD-1:0]     shifted,
  output logic [DATA_WD-1:0]     header
);

  localparam int CW = BYTE_CNT_WD + 1;

  logic [CW-1:0]      rem;
  logic [DATA_WD-1:0] lead;

  // Lanes 0..n-1 slide to the bottom (header / tail of the previous beat);
  // lanes n.. slide to the top to become the next residual.
  always_comb begin
    rem     = CW'(DATA_BYTE_WD) - {1'b0, n};
    shifted = data_in << {n, 3'b000};
    lead    = (n == '0) ? '0 : (data_in >> {rem, 3'b000});
    header  = lead;
    merged  = residual | lead;
  end

endmodule

// File: rtl/axi_stream_header_strip.sv
// Strips an n-byte (0..DATA_BYTE_WD-1) header from each packet, repacks the payload into full beats.
// Payload: 1 cycle after the 2nd accepted beat (1 cycle after the 1st for n=0 or single-beat); header 1 cycle after the 1st.
// ready_in follows the output register's free state and drops for the one TAIL cycle; header port has no backpressure.
module axi_stream_header_strip
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr
);

  localparam int CW = BYTE_CNT_WD + 1;

  axis_state_t              state, state_nxt;
  logic [BYTE_CNT_WD-1:0]   n_q, n_cur;
  logic [CW-1:0]            n_ext, k_in;
  logic [DATA_WD-1:0]       residual, res_nxt;
  logic [CW-1:0]            tail_cnt, tail_nxt;
  logic                     out_en, acc;
  logic                     emit, emit_last, hdr_fire;
  logic [DATA_WD-1:0]       emit_dat;
  logic [DATA_BYTE_WD-1:0]  emit_keep, hdr_keep;
  logic [DATA_WD-1:0]       merged, shifted, header;

  function automatic logic [DATA_BYTE_WD-1:0] msb_keep(input logic [CW-1:0] c);
    return DATA_BYTE_WD'(cnt_to_keep(CNT_W'(c), DATA_BYTE_WD));
  endfunction

  assign out_en   = !valid_out || ready_out;
  assign ready_in = (state != ST_TAIL) && out_en;
  assign acc      = valid_in && ready_in;
  // The strip count is live on the first beat and frozen for the rest of the packet.
  assign n_cur    = (state == ST_IDLE) ? byte_strip_cnt : n_q;
  assign n_ext    = {1'b0, n_cur};
  assign k_in     = CW'(keep_to_cnt(MAX_BYTES'(keep_in)));

  axis_byte_align #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_align (
    .residual (residual),
    .data_in  (data_in),
    .n        (n_cur),
    .merged   (merged),
    .shifted  (shifted),
    .header   (header)
  );

  // Header keep: n ones in the LSBs.
  always_comb begin
    hdr_keep = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      hdr_keep[i] = (i < int'(n_cur));
    end
  end

  // Next state and the beat (if any) to load into the output register.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_dat  = '0;
    emit_keep = '0;
    emit_last = 1'b0;
    res_nxt   = residual;
    tail_nxt  = tail_cnt;
    hdr_fire  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc) begin
          hdr_fire = 1'b1;
          res_nxt  = shifted;
          if (!last_in) begin
            state_nxt = ST_BODY;
            // n=0 is a straight pass-through: nothing is held back.
            if (n_cur == '0) begin
              emit      = 1'b1;
              emit_dat  = data_in;
              emit_keep = keep_in;
            end
          end else if (k_in > n_ext) begin
            emit      = 1'b1;
            emit_dat  = shifted;
            emit_keep = msb_keep(k_in - n_ext);
            emit_last = 1'b1;
          end
        end
      end
      ST_BODY: begin
        if (acc) begin
          emit    = 1'b1;
          res_nxt = shifted;
          if (n_cur == '0) begin
            emit_dat  = data_in;
            emit_keep = keep_in;
            emit_last = last_in;
            if (last_in) state_nxt = ST_IDLE;
          end else begin
            emit_dat  = merged;
            emit_keep = '1;
            if (last_in) begin
              if (k_in <= n_ext) begin
                emit_keep = msb_keep(CW'(DATA_BYTE_WD) - n_ext + k_in);
                emit_last = 1'b1;
                state_nxt = ST_IDLE;
              end else begin
                // Leftover bytes overflow this beat; flush them next cycle.
                tail_nxt  = k_in - n_ext;
                state_nxt = ST_TAIL;
              end
            end
          end
        end
      end
      ST_TAIL: begin
        if (out_en) begin
          emit      = 1'b1;
          emit_dat  = residual;
          emit_keep = msb_keep(tail_cnt);
          emit_last = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Packet context: strip count, carried bytes and tail length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      residual <= '0;
      tail_cnt <= '0;
    end else begin
      if (state == ST_IDLE && acc) n_q <= byte_strip_cnt;
      residual <= res_nxt;
      tail_cnt <= tail_nxt;
    end
  end

  // Payload output register; held while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (out_en) begin
      valid_out <= emit;
      if (emit) begin
        data_out <= emit_dat;
        keep_out <= emit_keep;
        last_out <= emit_last;
      end
    end
  end

  // Header side port: one-cycle pulse per packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_hdr <= 1'b0;
      data_hdr  <= '0;
      keep_hdr  <= '0;
    end else begin
      valid_hdr <= hdr_fire;
      if (hdr_fire) begin
        data_hdr <= header;
        keep_hdr <= hdr_keep;
      end
    end
  end

endmodule

// File: doc/axi_stream_header_strip.md
# axi_stream_header_strip

Receive-side counterpart of the header-insert stage. It removes a per-packet header of 0 to DATA_BYTE_WD-1 leading bytes from an AXI-Stream packet and presents the header on a side port. It re-packs the remaining payload so every non-last output beat is full, and the last beat's keep is MSB-contiguous. It sits directly downstream of the header-insert stage, or of the link that carries its output, and feeds the payload consumer.

## Interface
Parameters:
- DATA_WD, 32, data bus width in bits.
- DATA_BYTE_WD, DATA_WD/8, byte lanes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of the strip count.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- byte_strip_cnt  in  BYTE_CNT_WD  header length n in bytes; sampled on each packet's first accepted beat.
- valid_in  in  1  upstream beat valid.
- data_in  in  DATA_WD  upstream data.
- keep_in  in  DATA_BYTE_WD  upstream keep.
- last_in  in  1  upstream last beat.
- ready_in  out  1  block accepts the upstream beat.
- valid_out  out  1  payload beat valid.
- data_out  out  DATA_WD  payload data.
- keep_out  out  DATA_BYTE_WD  payload keep.
- last_out  out  1  payload last beat.
- ready_out  in  1  downstream accepts the payload beat.
- valid_hdr  out  1  one-cycle pulse: header captured. There is no backpressure on this port.
- data_hdr  out  DATA_WD  header bytes, LSB-aligned, unused upper bytes zero.
- keep_hdr  out  DATA_BYTE_WD  header keep, n ones in the LSBs.

## Operation
Byte and keep conventions:
- Byte lane 0 is data[DATA_WD-1 -: 8] and maps to keep[DATA_BYTE_WD-1].
- Non-last input beats carry keep all ones.
- Last input beats carry an MSB-contiguous keep with k ones, 1 ≤ k ≤ DATA_BYTE_WD. Any other keep gives undefined data, but the FSM still returns to IDLE on last_in.

State machine:
- IDLE, waiting for the first beat. On acceptance, latch n.
  - Header = lanes 0..n-1 → data_hdr, keep_hdr, valid_hdr.
  - Lanes n..DATA_BYTE_WD-1 go to the residual register, left-shifted by n bytes.
  - If not last_in, go to BODY.
  - If last_in and k>n, emit one beat with k-n bytes and last_out; stay IDLE.
  - If last_in and k≤n, emit no payload beat; stay IDLE.
- BODY: each accepted beat emits data_out = residual | (data_in >> 8*(DATA_BYTE_WD-n)).
  - The new residual is data_in << 8n.
  - On last_in with k≤n: emit the final beat with DATA_BYTE_WD-n+k bytes and last_out; go to IDLE.
  - On last_in with k>n: emit a full beat (keep all ones), go to TAIL.
- TAIL: ready_in=0. Emit the residual with k-n bytes and last_out. Go to IDLE when it is accepted.
- n=0 is a pass-through with one register stage. The residual is unused, and valid_hdr still pulses with keep_hdr=0.

Arithmetic:
- All shifts are in whole bytes.
- Byte counts use BYTE_CNT_WD+1 bits, so k=DATA_BYTE_WD is representable.

## Timing
- Reset values: all outputs 0, FSM=IDLE, residual=0. Reset asserted mid-packet discards the partial packet at once. The next packet starts in IDLE.
- The output register is updated only when !valid_out || ready_out.
- ready_in = (state!=TAIL) && (!valid_out || ready_out).
- Latency:
  - The first payload beat appears the cycle after the second input beat is accepted.
  - For n=0, or a single-beat packet, it appears the cycle after the first beat.
- valid_hdr is high the cycle after the first beat is accepted.
- Throughput: one beat per cycle with ready_out=1. Add one extra cycle per packet when TAIL is entered.
- While valid_out && !ready_out, data_out, keep_out and last_out are held stable.
- A new packet's first beat can be accepted in the cycle TAIL's beat is accepted, or the cycle after a last beat from BODY.

## Structure
- Shared package axi_stream_pkg:
  - keep→byte-count function.
  - byte-count→MSB-contiguous keep function.
  - state encoding (IDLE/BODY/TAIL).
- These are shared with axi_stream_header_insert.
- One natural sub-module is axis_byte_align, the combinational residual/shift merge. Everything else stays in the top.

## Test plan
- n=0: 0xAABBCCDD, 0x11223344, then 0x5566xxxx keep 1100 last → identical 3 beats out at 1-cycle latency; keep_hdr=0000.
- n=3: 0xA1A2A3D0, 0xD1D2D3D4, then 0xD5D6D7xx keep 1110 last → data_hdr=0x00A1A2A3 keep_hdr=0111; out 0xD0D1D2D3 keep 1111, then 0xD4D5D6D7 keep 1111 last; TAIL is not entered.
- n=1: 0xEED0D1D2, then 0xD3D4D5D6 keep 1111 last → out 0xD0D1D2D3 keep 1111, then 0xD4D5D6xx keep 1110 last. ready_in is low for exactly the TAIL cycle.
- n=2, single beat 0xAABBCCDD keep 1111 last → data_hdr=0x0000AABB keep_hdr=0011; out 0xCCDDxxxx keep 1100 last. A second identical packet the following cycle is accepted without a bubble.
- n=2, ready_out low for 3 cycles mid-packet of 10 beats → output held stable, ready_in low, and every payload byte is delivered in order.
- rst_n pulsed low mid-BODY → all outputs 0 asynchronously. The next packet with n=1 strips correctly from its first beat.
